// File: rtl/apb_wait_regfile_slave.sv
`timescale 1ns/1ps
// APB3 completer holding the four lab registers plus a read-only write counter.
// Programmable wait states before PREADY, and PSLVERR on bad decode.
//
// Ports:
//   PCLK     bus clock, rising edge
//   PRESET   asynchronous active-high reset
//   PSEL     completer select
//   PENABLE  access-phase indicator
//   PWRITE   1 = write, 0 = read
//   PADDR    byte address (32b)
//   PWDATA   write data (32b)
//   PRDATA   read data; nonzero only on a completing, non-error read
//   PREADY   transfer completes when PSEL=PENABLE=PREADY=1
//   PSLVERR  error response, qualified by PREADY
//
// Register map: 0x0 number_in_group, 0x4 date, 0x8 surname, 0xC name (RW),
//               0x10 write counter (RO).
module apb_wait_regfile_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RST_VAL     = 32'h0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  typedef enum logic {StIdle, StAccess} state_e;

  localparam logic [2:0] WaitInit = 3'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] reg_q [4];
  logic [31:0] wcnt_q;

  logic        ready;
  logic        commit;
  logic        err;
  logic        is_cnt;
  logic [1:0]  idx;
  logic [31:0] rdata_sel;

  // Decode always works on the latched setup values, never on the live bus.
  assign idx    = addr_q[3:2];
  assign is_cnt = (addr_q == 32'h10);
  assign err    = (addr_q[1:0] != 2'b00) || (addr_q > 32'h10) || (write_q && is_cnt);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    ready   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // PENABLE high here is not a setup phase and is ignored.
        if (PSEL && !PENABLE) begin
          state_d = StAccess;
          wait_d  = WaitInit;
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
        end
      end
      StAccess: begin
        if (wait_q == 3'd0) begin
          ready = 1'b1;
        end
        if (!PSEL) begin
          state_d = StIdle;
        end else if (wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else if (PENABLE) begin
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
      wait_q  <= 3'd0;
      addr_q  <= 32'h0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < 4; i++) begin
        reg_q[i] <= RST_VAL;
      end
      wcnt_q <= 32'h0;
    end else if (commit && write_q && !err) begin
      // Writes to 0x10 are errors, so a good write always targets a RW register.
      reg_q[idx] <= wdata_q;
      wcnt_q     <= wcnt_q + 32'd1;
    end
  end

  always_comb begin
    rdata_sel = is_cnt ? wcnt_q : reg_q[idx];
    PREADY    = ready;
    PSLVERR   = ready && err;
    PRDATA    = (ready && !write_q && !err) ? rdata_sel : 32'h0;
  end

endmodule

// File: tb/tb_apb_wait_regfile_slave.sv
`timescale 1ns/1ps
module tb_apb_wait_regfile_slave;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] rd_v;
  logic        err_v;
  int          wt_v;

  always #5 PCLK = ~PCLK;

  // Instance 0: WAIT_STATES=1, instance 1: 0, instance 2: 3.
  apb_wait_regfile_slave #(.WAIT_STATES(1), .RST_VAL(32'h0)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0])
  );
  apb_wait_regfile_slave #(.WAIT_STATES(0), .RST_VAL(32'h0)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1])
  );
  apb_wait_regfile_slave #(.WAIT_STATES(3), .RST_VAL(32'h0)) u_dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full transfer on instance d; bus values are scrambled during ACCESS
  // so only the latched setup values can produce the expected result.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd);
    bit got;
    got  = 1'b0;
    wt_v = 0;
    @(negedge PCLK);
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge PCLK);
    #1;
    penable = 1'b1; paddr = 32'hFFFF_FFF0; pwdata = 32'hA5A5_A5A5; pwrite = ~wr;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (pready[d]) begin
        got = 1'b1;
        break;
      end
      chk("prdata_zero_in_wait", prdata[d], 32'h0);
      wt_v++;
    end
    if (!got) chk("pready_timeout", 32'h0, 32'h1);
    rd_v  = prdata[d];
    err_v = pslverr[d];
    @(posedge PCLK);
    #1;
    psel[d] = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
  endtask

  task automatic wr_chk(input int d, input logic [31:0] a, input logic [31:0] v,
                        input int waits, input logic exp_err, input string tag);
    xfer(d, 1'b1, a, v);
    chk({tag, "_waits"}, 32'(wt_v), 32'(waits));
    chk({tag, "_err"}, {31'h0, err_v}, {31'h0, exp_err});
  endtask

  task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] exp,
                        input int waits, input logic exp_err, input string tag);
    xfer(d, 1'b0, a, 32'h0);
    chk({tag, "_data"}, rd_v, exp);
    chk({tag, "_waits"}, 32'(wt_v), 32'(waits));
    chk({tag, "_err"}, {31'h0, err_v}, {31'h0, exp_err});
  endtask

  initial begin
    PRESET = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    repeat (3) @(negedge PCLK);
    chk("rst_pready", {31'h0, pready[0]}, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr[0]}, 32'h0);
    chk("rst_prdata", prdata[0], 32'h0);
    PRESET = 1'b0;

    // WAIT_STATES=1 write/read
    rd_chk(0, 32'h10, 32'h0, 1, 1'b0, "cnt_init");
    wr_chk(0, 32'h0, 32'd12, 1, 1'b0, "wr_num");
    wr_chk(0, 32'h4, 32'h0111_2023, 1, 1'b0, "wr_date");
    rd_chk(0, 32'h0, 32'd12, 1, 1'b0, "rd_num");
    rd_chk(0, 32'h4, 32'h0111_2023, 1, 1'b0, "rd_date");
    rd_chk(0, 32'h10, 32'd2, 1, 1'b0, "cnt_2");

    // Surname/name
    wr_chk(0, 32'h8, 32'h6B75_726B, 1, 1'b0, "wr_surname");
    wr_chk(0, 32'hC, 32'h616E_6173, 1, 1'b0, "wr_name");
    rd_chk(0, 32'h0, 32'd12, 1, 1'b0, "rd4_num");
    rd_chk(0, 32'h4, 32'h0111_2023, 1, 1'b0, "rd4_date");
    rd_chk(0, 32'h8, 32'h6B75_726B, 1, 1'b0, "rd4_surname");
    rd_chk(0, 32'hC, 32'h616E_6173, 1, 1'b0, "rd4_name");
    rd_chk(0, 32'h10, 32'd4, 1, 1'b0, "cnt_4");

    // Errors
    wr_chk(0, 32'h10, 32'd5, 1, 1'b1, "err_wr_cnt");
    rd_chk(0, 32'h14, 32'h0, 1, 1'b1, "err_rd_14");
    wr_chk(0, 32'h2, 32'd7, 1, 1'b1, "err_wr_unaligned");
    rd_chk(0, 32'h10, 32'd4, 1, 1'b0, "cnt_after_err");
    rd_chk(0, 32'h0, 32'd12, 1, 1'b0, "num_after_err");

    // Abort: drop PSEL during the wait cycle
    @(negedge PCLK);
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'd9;
    @(posedge PCLK);
    #1 penable = 1'b1;
    @(negedge PCLK);
    chk("abort_wait_pready", {31'h0, pready[0]}, 32'h0);
    psel[0] = 1'b0;
    @(negedge PCLK);
    penable = 1'b0;
    chk("abort_idle_pready", {31'h0, pready[0]}, 32'h0);
    rd_chk(0, 32'h0, 32'd12, 1, 1'b0, "abort_num");
    rd_chk(0, 32'h10, 32'd4, 1, 1'b0, "abort_cnt");

    // WAIT_STATES=0 and 3
    wr_chk(1, 32'h8, 32'hCAFE_0001, 0, 1'b0, "ws0_wr");
    rd_chk(1, 32'h8, 32'hCAFE_0001, 0, 1'b0, "ws0_rd");
    wr_chk(2, 32'h8, 32'hBEEF_0003, 3, 1'b0, "ws3_wr");
    rd_chk(2, 32'h8, 32'hBEEF_0003, 3, 1'b0, "ws3_rd");

    // Reset mid-transfer on a completing zero-wait read
    @(negedge PCLK);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
    @(posedge PCLK);
    #1 penable = 1'b1;
    #1;
    chk("pre_rst_prdata", prdata[1], 32'hCAFE_0001);
    #1 PRESET = 1'b1;
    #1;
    chk("mid_rst_pready", {31'h0, pready[1]}, 32'h0);
    chk("mid_rst_pslverr", {31'h0, pslverr[1]}, 32'h0);
    chk("mid_rst_prdata", prdata[1], 32'h0);
    @(negedge PCLK);
    psel = 3'b000; penable = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    rd_chk(1, 32'h0, 32'h0, 0, 1'b0, "post_rst_num");
    rd_chk(1, 32'h4, 32'h0, 0, 1'b0, "post_rst_date");
    rd_chk(1, 32'h8, 32'h0, 0, 1'b0, "post_rst_surname");
    rd_chk(1, 32'hC, 32'h0, 0, 1'b0, "post_rst_name");
    rd_chk(1, 32'h10, 32'h0, 0, 1'b0, "post_rst_cnt");
    rd_chk(0, 32'h0, 32'h0, 1, 1'b0, "post_rst_num_d0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_wait_regfile_slave.md
Name: apb_wait_regfile_slave

Overview:
- APB3 completer (responder) for the lab APB bus: the other end of the existing APB master.
- Holds the four lab registers: number_in_group 0x0, date 0x4, surname 0x8, name 0xC.
- Adds a read-only write-counter register at 0x10, programmable wait states, and PSLVERR error signalling.
- Instantiated behind the APB master in the lab top level and its benches.

Parameters:
- WAIT_STATES, 1, number of access-phase cycles with PREADY=0 before completion; legal range 0..7.
- RST_VAL, 32'h0, reset value of all four RW registers.

Ports:
- PCLK  input  1  bus clock; all state changes on the rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  byte address.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer completes in a cycle where PSEL=PENABLE=PREADY=1.
- PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1, async):
  - FSM goes to IDLE; wait counter = 0.
  - All RW registers = RST_VAL; write counter = 0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - Reset asserted mid-transfer aborts it; no register changes.
- FSM states:
  - IDLE: on PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PWDATA, load wait counter with WAIT_STATES, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS with wait counter != 0: decrement the counter, hold PREADY=0.
  - ACCESS with wait counter == 0: PREADY=1 combinationally. At the next edge, if PSEL=PENABLE=1, the transfer commits and the FSM returns to IDLE.
  - ACCESS with PSEL=0 at any edge: abort, return to IDLE, nothing committed.
- Back-to-back transfers: a setup phase in the cycle after completion is accepted normally from IDLE.
- Latency: completion occurs WAIT_STATES+1 cycles after the setup edge. WAIT_STATES=0 gives a zero-wait access (PREADY=1 in the first access cycle).
- Latched setup values are used for the whole transfer; changes to PADDR/PWDATA/PWRITE during ACCESS are ignored.
- Address decode (on the latched address):
  - 0x0, 0x4, 0x8, 0xC: RW.
  - 0x10: RO write counter.
  - Error if addr[1:0] != 0, if addr > 0x10, or on a write to 0x10.
- Write commit:
  - Non-error: target register <= latched PWDATA; write counter increments by 1 and wraps from 32'hFFFFFFFF to 0.
  - Error: no register change; counter unchanged.
- Read data:
  - PRDATA = selected register value only while PREADY=1 and the latched PWRITE=0; otherwise 0.
  - Error reads return 0.
- PSLVERR = PREADY & error_decode; 0 at all other times.
- PENABLE=1 while in IDLE is ignored; no transfer starts.

Test Plan:
- Write/read, WAIT_STATES=1: write 12 to 0x0, write 32'h01112023 to 0x4, then read 0x0 and 0x4.
  -> Reads return 12 and 32'h01112023; PREADY low exactly 1 access cycle each; PSLVERR=0; reg 0x10 reads 2.
- Surname/name: write 0x6B75726B to 0x8 and 0x616E6173 to 0xC; read all four registers.
  -> Values match; reg 0x10 = 4.
- Errors: write 5 to 0x10; read 0x14; write 7 to 0x2.
  -> Each completes with PREADY=1, PSLVERR=1; PRDATA=0 for the read; registers and counter unchanged.
- WAIT_STATES=0 and WAIT_STATES=3: write then read 0x8.
  -> PREADY asserted 1 and 4 cycles after the setup edge respectively; data correct.
- Abort: setup a write of 9 to 0x0, drop PSEL during a wait cycle.
  -> FSM back to IDLE; 0x0 keeps its old value; counter unchanged.
- Reset mid-transfer: assert PRESET between clock edges during ACCESS.
  -> PREADY/PSLVERR/PRDATA go 0 immediately; after release, all registers read RST_VAL and the counter reads 0.
